// File: rtl/m_unpiler_pkg.sv
// m_unpiler_pkg: board geometry, undo-history sizing and FSM encodings shared by the un-pile path.
package m_unpiler_pkg;
    localparam int COL_COUNT              = 7;
    localparam int ROW_COUNT              = 6;
    localparam int FIELD_SIZE             = 42;
    localparam int COL_SIZE               = 3;
    localparam int ROW_SIZE               = 3;
    localparam int PILED_COUNT_ARRAY_SIZE = 21;
    localparam int UNDO_DEPTH             = 42;
    localparam int UNDO_PTR_W             = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_POP  = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Widened to 6 bits so COL_COUNT*row cannot truncate before the add.
    function automatic logic [5:0] cell_idx(input logic [ROW_SIZE-1:0] row, input logic [COL_SIZE-1:0] col);
        return 6'(COL_COUNT) * 6'(row) + 6'(col);
    endfunction
endpackage

// File: rtl/m_unpiler_if.sv
// m_unpiler_if: controller <-> un-piler signal bundle; the controller is the master.
interface m_unpiler_if;
    import m_unpiler_pkg::*;
    logic                              i_push;
    logic [COL_SIZE-1:0]               i_push_col;
    logic                              i_undo_req;
    logic [FIELD_SIZE-1:0]             i_field;
    logic [PILED_COUNT_ARRAY_SIZE-1:0] i_piled_count_array;
    logic                              o_busy;
    logic                              o_done;
    logic                              o_err;
    logic [COL_SIZE-1:0]               o_undo_col;
    logic [FIELD_SIZE-1:0]             o_field;
    logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_count_array;
    logic [UNDO_PTR_W-1:0]             o_depth;
    logic                              o_empty;

    modport master (
        output i_push, i_push_col, i_undo_req, i_field, i_piled_count_array,
        input  o_busy, o_done, o_err, o_undo_col, o_field, o_piled_count_array, o_depth, o_empty
    );
    modport slave (
        input  i_push, i_push_col, i_undo_req, i_field, i_piled_count_array,
        output o_busy, o_done, o_err, o_undo_col, o_field, o_piled_count_array, o_depth, o_empty
    );
endinterface

// File: rtl/m_move_stack.sv
// m_move_stack: LIFO of played columns; push ignored when full, pop ignored when empty.
module m_move_stack #(
    parameter int DEPTH = 42,
    parameter int PTR_W = 6,
    parameter int W     = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_top,
    output logic [PTR_W-1:0] o_depth,
    output logic             o_full,
    output logic             o_empty
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] depth_q, depth_d;

    assign o_full  = depth_q == PTR_W'(DEPTH);
    assign o_empty = depth_q == '0;
    assign o_depth = depth_q;
    assign o_top   = mem_q[depth_q - PTR_W'(1)];

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (i_push && !o_full) begin
            mem_d[depth_q] = i_data;
            depth_d        = depth_q + PTR_W'(1);
        end else if (i_pop && !o_empty) begin
            depth_d = depth_q - PTR_W'(1);
        end
    end

    // Entries carry no reset: only the depth count defines what is valid.
    always_ff @(posedge i_clk) mem_q <= mem_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) depth_q <= '0;
        else          depth_q <= depth_d;
    end
endmodule

// File: rtl/m_unpiler.sv
// m_unpiler: pops the last played column and removes its top piece from the field and height array.
module m_unpiler
    import m_unpiler_pkg::*;
#(
    parameter int DEPTH = UNDO_DEPTH,
    parameter int PTR_W = UNDO_PTR_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    m_unpiler_if.slave bus
);
    logic [1:0]                        state_q, state_d;
    logic [COL_SIZE-1:0]               col_q, col_d, undo_col_q, undo_col_d;
    logic [FIELD_SIZE-1:0]             field_q, field_d;
    logic [PILED_COUNT_ARRAY_SIZE-1:0] piled_q, piled_d;
    logic                              err_q, err_d;
    logic [ROW_SIZE-1:0]               h;
    logic [COL_SIZE-1:0]               top;
    logic [PTR_W-1:0]                  depth;
    logic                              full, empty, idle;

    assign idle = state_q == S_IDLE;
    assign h    = bus.i_piled_count_array[ROW_SIZE*col_q +: ROW_SIZE];

    m_move_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(COL_SIZE)) u_stack (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (idle && bus.i_push),
        .i_pop   (state_q == S_POP),
        .i_data  (bus.i_push_col),
        .o_top   (top),
        .o_depth (depth),
        .o_full  (full),
        .o_empty (empty)
    );

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        undo_col_d = undo_col_q;
        field_d    = field_q;
        piled_d    = piled_q;
        err_d      = 1'b0;
        if (idle) begin
            if (bus.i_push) begin
                err_d = full;
            end else if (bus.i_undo_req) begin
                err_d   = empty;
                state_d = empty ? S_IDLE : S_POP;
            end
        end else begin
            err_d = bus.i_push;
            if (state_q == S_POP) begin
                col_d   = top;
                state_d = S_CALC;
            end else if (state_q == S_CALC) begin
                // A zero height means history and field disagree; the popped entry stays discarded.
                if (h == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    field_d = bus.i_field & ~(FIELD_SIZE'(1) << cell_idx(h - ROW_SIZE'(1), col_q));
                    piled_d = bus.i_piled_count_array;
                    piled_d[ROW_SIZE*col_q +: ROW_SIZE] = h - ROW_SIZE'(1);
                    undo_col_d = col_q;
                    state_d    = S_DONE;
                end
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            undo_col_q <= '0;
            field_q    <= '0;
            piled_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            undo_col_q <= undo_col_d;
            field_q    <= field_d;
            piled_q    <= piled_d;
            err_q      <= err_d;
        end
    end

    assign bus.o_busy              = !idle;
    assign bus.o_done              = state_q == S_DONE;
    assign bus.o_err               = err_q;
    assign bus.o_undo_col          = undo_col_q;
    assign bus.o_field             = field_q;
    assign bus.o_piled_count_array = piled_q;
    assign bus.o_depth             = UNDO_PTR_W'(depth);
    assign bus.o_empty             = empty;
endmodule

// File: doc/m_unpiler.md
Name: m_unpiler

Overview:
- Reverse path of the piece-dropping logic: keeps a LIFO history of played columns.
- On an undo request, pops the last column and returns the field with that column's top piece cleared, plus the piled-count array with that column decremented.
- Sits beside the drop logic in the game controller. The controller pushes each accepted drop and writes back the undo result on o_done.

Parameters:
- DEPTH, `FIELD_SIZE (42): history depth, one entry per cell.
- PTR_W, 6: width of the stack pointer and depth count; it must satisfy 2^PTR_W > DEPTH.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_push  in  1  one-cycle strobe: the controller committed a valid drop this cycle
- i_push_col  in  `COL_SIZE  column of that drop, 0..`COL_COUNT-1
- i_undo_req  in  1  level; held until o_done
- i_field  in  `FIELD_SIZE  current field, bit index = `COL_COUNT*row + col, row 0 = bottom
- i_piled_count_array  in  `PILED_COUNT_ARRAY_SIZE  per-column heights, `ROW_SIZE bits per column, column c at bits [c*`ROW_SIZE +: `ROW_SIZE]
- o_busy  out  1  FSM not in IDLE
- o_done  out  1  one-cycle pulse: the undo result is valid
- o_err  out  1  one-cycle pulse: request rejected
- o_undo_col  out  `COL_SIZE  column that was un-piled
- o_field  out  `FIELD_SIZE  field with the piece removed
- o_piled_count_array  out  `PILED_COUNT_ARRAY_SIZE  heights after removal
- o_depth  out  PTR_W  number of stored moves
- o_empty  out  1  o_depth == 0

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE and the depth count goes to 0.
  - All outputs read 0, except o_empty, which reads 1.
  - Stack contents are don't-care.
  - A reset asserted mid-undo aborts the undo: no o_done and no o_err are emitted.
- FSM states: IDLE, POP, CALC, DONE.
- IDLE:
  - i_push has priority over i_undo_req.
  - On i_push, if depth < DEPTH: write stack[depth] = i_push_col and increment depth. If depth == DEPTH: o_err pulses next cycle and depth is unchanged.
  - On i_undo_req with no i_push in the same cycle: if depth == 0, o_err pulses next cycle and the FSM stays in IDLE; otherwise go to POP.
  - If i_push and i_undo_req arrive together, the push is taken. The undo is evaluated in the next IDLE cycle, because i_undo_req is a level.
- POP:
  - r_col = stack[depth-1]; decrement depth; go to CALC.
  - i_push while not in IDLE is dropped and o_err pulses.
- CALC:
  - h = the count field for r_col in i_piled_count_array.
  - If h == 0 (history and field disagree): o_err pulses, the outputs keep their previous values, the popped entry is not restored, and the FSM returns to IDLE.
  - Otherwise:
    - o_field = i_field & ~(1 << (`COL_COUNT*(h-1) + r_col)).
    - o_piled_count_array = the input array with that column's field set to h-1.
    - o_undo_col = r_col.
    - Go to DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- Latency: o_done is high in the 3rd cycle after the accepting edge (IDLE→POP→CALC→DONE).
- i_field and i_piled_count_array must be stable from acceptance through CALC.
- o_field, o_piled_count_array and o_undo_col are registered and hold until the next successful undo.
- Arithmetic:
  - h-1 is evaluated only when h ≥ 1.
  - The bit-index product is computed at width ≥ 6 bits to avoid truncation.
  - Depth never wraps in either direction.

Decomposition:
- The codebase's shared config.vh supplies `COL_COUNT=7, `ROW_COUNT=6, `FIELD_SIZE=42, `COL_SIZE=3, `ROW_SIZE=3 and `PILED_COUNT_ARRAY_SIZE=21.
- Add to config.vh: `UNDO_DEPTH=42 and the state encodings (IDLE=0, POP=1, CALC=2, DONE=3).
- One sub-module: m_move_stack, a LIFO with a register array, push/pop, full/empty and a depth count. The FSM and the un-pile arithmetic stay in m_unpiler.

Test Plan:
- Push col 3; drive field bit 3 and col-3 height 1; raise undo → o_done 3 cycles later, o_field bit 3 = 0, col-3 height 0, o_undo_col = 3, o_empty = 1.
- Push col 3 twice; field bits 3 and 10; height 2; undo → bit 10 cleared, bit 3 kept, height 1, o_depth = 1.
- Undo with depth 0 → o_err pulse, no o_done, outputs and depth unchanged.
- 42 pushes, then a 43rd push (col 0) → o_err, o_depth stays 42. Then 42 undos return the columns in reverse push order.
- Push col 5 and raise undo in the same cycle → depth goes 0→1 and the undo then pops col 5. Separately: a stored entry whose column height is 0 → o_err in CALC and o_depth decrements.
- Assert i_rst_n=0 while in CALC → immediately o_busy = 0, o_depth = 0, o_empty = 1, and no o_done after release.
